wb_register_file: RTL and testbench

- 32 x 64-bit integer register file for the pipelined core. It is the consumer end of the writeback interface.
- Accepts wb_RegWrite / wb_rd / wb_registerout from the writeback stage and commits them on the clock edge.
- Serves two combinational read ports to the decode stage and one debug read port for benches.
- Keeps a retired-write counter and a per-register "written since reset" mask for verification visibility.

---
 rtl/wb_register_file.sv | 105 ++++++++++
 tb/tb_wb_register_file.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// 32 x XLEN integer register file at the consumer end of the writeback interface.
// Optional macro RF_BYPASS_EN adds same-cycle write-through forwarding on rs1/rs2.
module wb_register_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_RegWrite,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_registerout,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic [CNT_W-1:0]         wr_count,
  output logic [NREGS-1:0]         written_mask,
  output logic [$clog2(NREGS)-1:0] last_wr_rd
);

  localparam int IDX_W = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_wr_count;
  logic [NREGS-1:0] r_written_mask;
  logic [IDX_W-1:0] r_last_wr_rd;
  logic             w_commit;
  logic [XLEN-1:0]  w_rs1_stored;
  logic [XLEN-1:0]  w_rs2_stored;
  logic [XLEN-1:0]  w_dbg_stored;

  // Writes to x0 are dropped entirely, including all bookkeeping.
  assign w_commit = wb_RegWrite && (wb_rd != {IDX_W{1'b0}});

  // Register array and write bookkeeping; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
      r_wr_count     <= {CNT_W{1'b0}};
      r_written_mask <= {NREGS{1'b0}};
      r_last_wr_rd   <= {IDX_W{1'b0}};
    end else if (w_commit) begin
      r_regs[wb_rd]         <= wb_registerout;
      r_wr_count            <= r_wr_count + CNT_W'(1);
      r_written_mask[wb_rd] <= 1'b1;
      r_last_wr_rd          <= wb_rd;
    end else begin
      r_wr_count <= r_wr_count;
    end
  end

  // Stored-value reads; x0 is forced to zero on every port.
  always_comb begin
    w_rs1_stored = {XLEN{1'b0}};
    w_rs2_stored = {XLEN{1'b0}};
    w_dbg_stored = {XLEN{1'b0}};
    if (rs1_addr != {IDX_W{1'b0}}) begin
      w_rs1_stored = r_regs[rs1_addr];
    end else begin
      w_rs1_stored = {XLEN{1'b0}};
    end
    if (rs2_addr != {IDX_W{1'b0}}) begin
      w_rs2_stored = r_regs[rs2_addr];
    end else begin
      w_rs2_stored = {XLEN{1'b0}};
    end
    if (dbg_addr != {IDX_W{1'b0}}) begin
      w_dbg_stored = r_regs[dbg_addr];
    end else begin
      w_dbg_stored = {XLEN{1'b0}};
    end
  end

  // Decode read ports; forwarding is gated by reset so reads stay 0 during reset.
  always_comb begin
    rs1_data = w_rs1_stored;
    rs2_data = w_rs2_stored;
`ifdef RF_BYPASS_EN
    if (w_commit && !reset && (wb_rd == rs1_addr)) begin
      rs1_data = wb_registerout;
    end else begin
      rs1_data = w_rs1_stored;
    end
    if (w_commit && !reset && (wb_rd == rs2_addr)) begin
      rs2_data = wb_registerout;
    end else begin
      rs2_data = w_rs2_stored;
    end
`else
    rs1_data = w_rs1_stored;
    rs2_data = w_rs2_stored;
`endif
  end

  assign dbg_data     = w_dbg_stored;
  assign wr_count     = r_wr_count;
  assign written_mask = r_written_mask;
  assign last_wr_rd   = r_last_wr_rd;

endmodule

// File: tb/tb_wb_register_file.sv
// Scoreboard bench for wb_register_file: driver pushes expected pre-edge outputs, a
// negedge monitor pops and compares. Counter is narrowed to 4 bits to exercise wrap.
module tb_wb_register_file;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  dbg;
    logic [CNT_W-1:0] cnt;
    logic [NREGS-1:0] mask;
    logic [4:0]       last;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             wb_RegWrite;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_registerout;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [4:0]       dbg_addr;
  logic [XLEN-1:0]  dbg_data;
  logic [CNT_W-1:0] wr_count;
  logic [NREGS-1:0] written_mask;
  logic [4:0]       last_wr_rd;

  wb_register_file #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_registerout(wb_registerout), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count), .written_mask(written_mask), .last_wr_rd(last_wr_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays and integers.
  logic [XLEN-1:0] m_regs [32];
  int unsigned     m_cnt;
  logic [31:0]     m_mask;
  int unsigned     m_last;
  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;

  function automatic logic [XLEN-1:0] m_read(input int unsigned a);
    return (a == 0) ? 64'd0 : m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, predict pre-edge outputs, then apply the edge to the model.
  task automatic step(input bit rst, input bit we, input int unsigned rd, input logic [XLEN-1:0] d,
                      input int unsigned a1, input int unsigned a2, input int unsigned ad);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; wb_RegWrite = we; wb_rd = rd[4:0]; wb_registerout = d;
    rs1_addr = a1[4:0]; rs2_addr = a2[4:0]; dbg_addr = ad[4:0];
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_cnt = 0; m_mask = 32'd0; m_last = 0;
    end
    e.rs1 = m_read(a1);
    e.rs2 = m_read(a2);
    e.dbg = m_read(ad);
`ifdef RF_BYPASS_EN
    if (!rst && we && rd != 0 && rd == a1) e.rs1 = d;
    if (!rst && we && rd != 0 && rd == a2) e.rs2 = d;
`endif
    e.cnt  = CNT_W'(m_cnt % (1 << CNT_W));
    e.mask = m_mask;
    e.last = m_last[4:0];
    q.push_back(e);
    if (!rst && we && rd != 0) begin
      m_regs[rd] = d;
      m_cnt      = m_cnt + 1;
      m_mask[rd] = 1'b1;
      m_last     = rd;
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation at mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", rs1_data, e.rs1);
      chk("rs2_data", rs2_data, e.rs2);
      chk("dbg_data", dbg_data, e.dbg);
      chk("wr_count", {60'd0, wr_count}, {60'd0, e.cnt});
      chk("written_mask", {32'd0, written_mask}, {32'd0, e.mask});
      chk("last_wr_rd", {59'd0, last_wr_rd}, {59'd0, e.last});
    end
  end

  initial begin
    int budget;
    reset = 1'b1; wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_registerout = 64'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_cnt = 0; m_mask = 32'd0; m_last = 0;

    step(1, 0, 0, 64'd0, 0, 0, 0);
    // Write arriving in the first cycle after reset deasserts, then mid-cycle reset.
    step(0, 1, 5, 64'hDEAD, 5, 0, 5);
    step(0, 0, 0, 64'd0, 5, 5, 5);
    step(1, 1, 6, 64'h1234, 5, 6, 5);
    step(1, 1, 9, 64'h55, 5, 9, 9);
    // Basic write/read pair.
    step(0, 1, 10, 64'd100, 0, 0, 0);
    step(0, 1, 15, 64'd200, 10, 0, 10);
    step(0, 0, 0, 64'd0, 10, 15, 15);
    // x0 protection and write disable.
    step(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    step(0, 0, 10, 64'd999, 0, 10, 0);
    step(0, 0, 0, 64'd0, 10, 10, 10);
    // Same-cycle hazard on x7.
    step(0, 1, 7, 64'd1, 0, 0, 0);
    step(0, 1, 7, 64'd2, 7, 7, 7);
    step(0, 0, 0, 64'd0, 7, 0, 7);
    // Back-to-back same rd, then a run that wraps the narrow counter.
    step(0, 1, 3, 64'hAAAA, 0, 0, 0);
    step(0, 1, 3, 64'hBBBB, 3, 0, 3);
    for (int i = 0; i < 18; i++) step(0, 1, (i % 31) + 1, 64'(i * 3 + 1), 3, i % 32, 3);
    step(0, 0, 0, 64'd0, 3, 17, 18);
    // Randomized traffic with occasional resets and frequent read-after-write collisions.
    for (int n = 0; n < 400; n++) begin
      int unsigned rd;
      int unsigned a1;
      bit rst;
      rd  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      a1  = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 31);
      rst = ($urandom_range(0, 49) == 0);
      step(rst, $urandom_range(0, 3) != 0, rd, {$urandom, $urandom}, a1,
           $urandom_range(0, 31), $urandom_range(0, 31));
    end
    step(0, 0, 0, 64'd0, 0, 0, 0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
